// File: rtl/mem_a_read_requester.sv
// Purpose : pops A-addresses from a FWFT FIFO, issues in-order memory reads, forwards beats to the row FIFO.
// Latency : pop -> mem_req_valid 1 cycle; mem_rsp_valid -> row_fifo_push 2 cycles minimum.
// Backpressure: mem_req_ready stalls the held request; row_fifo_full stalls the beat buffer; credits cap issue.
//
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   start_i, total_reads             job launch pulse and address count (sampled in IDLE)
//   addr_fifo_data/empty/pop         A-address FIFO head, empty flag, combinational pop
//   mem_req_valid/addr/ready         registered read request channel
//   mem_rsp_valid/data               in-order read beats
//   row_fifo_data/push/full          registered push to the downstream row FIFO
//   busy_o, done_o, err_o            status: not idle, job-complete pulse, sticky orphan-response flag
module mem_a_read_requester #(
    parameter int MEM_DATA_WIDTH_BYTES = 32,
    parameter int MAX_OUTSTANDING      = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start_i,
    input  logic [15:0]                       total_reads,
    input  logic [15:0]                       addr_fifo_data,
    input  logic                              addr_fifo_empty,
    output logic                              addr_fifo_pop,
    output logic                              mem_req_valid,
    output logic [15:0]                       mem_req_addr,
    input  logic                              mem_req_ready,
    input  logic                              mem_rsp_valid,
    input  logic [MEM_DATA_WIDTH_BYTES*8-1:0] mem_rsp_data,
    output logic [MEM_DATA_WIDTH_BYTES*8-1:0] row_fifo_data,
    output logic                              row_fifo_push,
    input  logic                              row_fifo_full,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              err_o
);

    localparam int DW = MEM_DATA_WIDTH_BYTES * 8;
    localparam int PW = $clog2(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] total_q;
    logic [15:0] popped_cnt;
    logic [15:0] issued_cnt;
    logic [15:0] recv_cnt;
    logic [15:0] outstanding;

    // Beat buffer: pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [DW-1:0] beat_mem [MAX_OUTSTANDING];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW:0]   buffered;
    logic          beat_empty;
    logic          beat_pop;

    logic          req_acc;
    logic          slot_free;
    logic [16:0]   credit_used;
    logic          credit_ok;
    logic          rsp_ok;
    logic          rsp_err;
    logic          run_done;
    logic          drain_done;

    assign req_acc    = mem_req_valid & mem_req_ready;
    assign slot_free  = ~mem_req_valid | mem_req_ready;

    assign buffered   = wr_ptr - rd_ptr;
    assign beat_empty = (wr_ptr == rd_ptr);
    assign beat_pop   = ~beat_empty & ~row_fifo_full;

    // Every read that can still land in the beat buffer holds a credit: the one waiting in the
    // request slot, the ones in flight, and the beats already buffered. Keeping that sum below
    // the buffer depth before each pop is what makes the buffer overflow-free.
    assign credit_used = {1'b0, outstanding} + 17'(buffered) + 17'(mem_req_valid);
    assign credit_ok   = credit_used < 17'(MAX_OUTSTANDING);

    assign addr_fifo_pop = (state == RUN) && ~addr_fifo_empty && (popped_cnt < total_q)
                           && slot_free && credit_ok;

    // A beat is legitimate if something is in flight, or the read is being accepted this very cycle.
    assign rsp_ok  = mem_rsp_valid & ((outstanding != 16'd0) | req_acc);
    assign rsp_err = mem_rsp_valid & ~rsp_ok;

    assign run_done   = (issued_cnt == total_q) && ~mem_req_valid;
    assign drain_done = (recv_cnt == total_q) && beat_empty;

    assign busy_o = (state != IDLE);
    assign done_o = (state == DRAIN) && drain_done;

    // Control FSM, job counters and the sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            total_q     <= 16'd0;
            popped_cnt  <= 16'd0;
            issued_cnt  <= 16'd0;
            recv_cnt    <= 16'd0;
            outstanding <= 16'd0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (start_i)    state <= RUN;
                RUN:     if (run_done)   state <= DRAIN;
                DRAIN:   if (drain_done) state <= IDLE;
                default:                 state <= IDLE;
            endcase

            if (addr_fifo_pop) popped_cnt <= popped_cnt + 16'd1;
            if (req_acc)       issued_cnt <= issued_cnt + 16'd1;
            if (rsp_ok)        recv_cnt   <= recv_cnt + 16'd1;

            case ({req_acc, rsp_ok})
                2'b10:   outstanding <= outstanding + 16'd1;
                2'b01:   outstanding <= outstanding - 16'd1;
                default: outstanding <= outstanding;
            endcase

            if (rsp_err) err_o <= 1'b1;

            // A job launch overrides any stray update above: fresh counters, error cleared.
            if (state == IDLE && start_i) begin
                total_q     <= total_reads;
                popped_cnt  <= 16'd0;
                issued_cnt  <= 16'd0;
                recv_cnt    <= 16'd0;
                outstanding <= 16'd0;
                err_o       <= 1'b0;
            end
        end
    end

    // Single request slot: a pop refills it even while the current request is being accepted,
    // which sustains one request per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= 16'd0;
        end else if (addr_fifo_pop) begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= addr_fifo_data;
        end else if (req_acc) begin
            mem_req_valid <= 1'b0;
        end
    end

    // Beat storage has no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (rsp_ok) beat_mem[wr_ptr[PW-1:0]] <= mem_rsp_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            row_fifo_push <= 1'b0;
            row_fifo_data <= '0;
        end else begin
            if (rsp_ok) wr_ptr <= wr_ptr + 1'b1;
            row_fifo_push <= beat_pop;
            if (beat_pop) begin
                row_fifo_data <= beat_mem[rd_ptr[PW-1:0]];
                rd_ptr        <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_a_read_requester.md
MEM_A_READ_REQUESTER -- requirements
Module: mem_a_read_requester

Interface
REQ-001 SHALL have parameter MEM_DATA_WIDTH_BYTES, default 32, meaning bytes per memory read beat.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the credit limit: in-flight reads plus buffered beats (power of 2, at least 2).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1  meaning one-cycle pulse that launches a job; ignored unless IDLE.
REQ-006 SHALL have port total_reads  input  16  meaning the number of addresses to consume, sampled on an accepted start.
REQ-007 SHALL have port addr_fifo_data  input  16  meaning the head of the A-address FIFO (first-word fall-through).
REQ-008 SHALL have port addr_fifo_empty  input  1  meaning the A-address FIFO is empty.
REQ-009 SHALL have port addr_fifo_pop  output  1  meaning a combinational pop strobe to the A-address FIFO.
REQ-010 SHALL have port mem_req_valid  output  1  meaning a read request is valid (registered).
REQ-011 SHALL have port mem_req_addr  output  16  meaning the read address (registered).
REQ-012 SHALL have port mem_req_ready  input  1  meaning memory accepts the request.
REQ-013 SHALL have port mem_rsp_valid  input  1  meaning a read beat is returning, in request order.
REQ-014 SHALL have port mem_rsp_data  input  MEM_DATA_WIDTH_BYTES*8  meaning the read beat.
REQ-015 SHALL have port row_fifo_data  output  MEM_DATA_WIDTH_BYTES*8  meaning the beat pushed downstream (registered).
REQ-016 SHALL have port row_fifo_push  output  1  meaning a push strobe (registered).
REQ-017 SHALL have port row_fifo_full  input  1  meaning downstream cannot accept a push.
REQ-018 SHALL have port busy_o  output  1  meaning the state is not IDLE.
REQ-019 SHALL have port done_o  output  1  meaning a one-cycle job-complete pulse.
REQ-020 SHALL have port err_o  output  1  meaning sticky: a response arrived with no read outstanding.

Function
REQ-021 SHALL implement an FSM with states IDLE, RUN and DRAIN.
- IDLE->RUN: on start_i; total_reads latched, all counters cleared, err_o cleared.
- RUN->DRAIN: when issued_cnt equals the latched total and no request is pending.
- DRAIN->IDLE: when recv_cnt equals the total and the beat buffer is empty; done_o is 1 that cycle.
REQ-022 SHALL, when start_i arrives with total_reads equal to 0, go IDLE->RUN->DRAIN->IDLE with done_o asserted 2 cycles after start and no pop or request.
REQ-023 SHALL assert addr_fifo_pop in RUN only when all of the following hold:
- addr_fifo_empty is 0;
- popped_cnt is less than the total;
- the request slot is free or is being accepted this cycle;
- outstanding plus buffered plus pending is less than MAX_OUTSTANDING.
REQ-024 SHALL load addr_fifo_data into mem_req_addr and set mem_req_valid on the clock edge that follows a pop (1-cycle latency).
REQ-025 SHALL hold mem_req_valid and mem_req_addr stable until mem_req_ready is 1; a request is accepted when mem_req_valid and mem_req_ready are both 1.
REQ-026 SHALL allow a back-to-back pop in the cycle a request is accepted, so one request per cycle is sustainable.
REQ-027 SHALL, on acceptance, increment issued_cnt and the outstanding counter.
REQ-028 SHALL, on mem_rsp_valid, write mem_rsp_data into an internal FIFO of depth MAX_OUTSTANDING, increment recv_cnt and decrement outstanding.
REQ-029 SHALL, on an acceptance and a response in the same cycle, leave outstanding unchanged.
REQ-030 SHALL, when a response arrives with outstanding equal to 0 (and no acceptance that cycle), set err_o, drop the data and leave the counters unchanged.
REQ-031 SHALL pop the beat FIFO whenever it is non-empty and row_fifo_full is 0; row_fifo_data and row_fifo_push are registered, so the beat appears 1 cycle after the pop.
REQ-032 SHALL deliver beats to the row FIFO in response order; the shortest path from mem_rsp_valid to row_fifo_push is 2 cycles.
REQ-033 SHALL keep all counters 16-bit; the credit-limit check guarantees the beat FIFO never overflows.
REQ-034 SHALL ignore start_i in RUN or DRAIN, with no effect on any counter.

Reset
REQ-035 SHALL, on reset_n low, immediately force the FSM to IDLE, clear every counter and the beat FIFO pointers, and drive every output to 0, including data and address buses.
REQ-036 SHALL abandon a job on mid-operation reset; beats returning after reset releases are flagged by err_o.

Verification
REQ-037 SHALL cover: total 4, FIFO preloaded with 0x0000, 0x0040, 0x0080, 0x00C0, ready tied 1, response latency 3 -> requests on consecutive cycles, 4 pushes in order, done_o once, busy_o low after.
REQ-038 SHALL cover: total 8, MAX_OUTSTANDING 4, response latency 10 -> outstanding never exceeds 4, pop stalls until responses return, 8 pushes.
REQ-039 SHALL cover: mem_req_ready low for 5 cycles on the 2nd request -> mem_req_addr stable throughout, no extra pop, no lost or duplicated address.
REQ-040 SHALL cover: row_fifo_full held 1 for 20 cycles -> at most 4 reads in flight or buffered, no push while full, all data delivered once full drops.
REQ-041 SHALL cover: start with total 0 -> done_o 2 cycles later, no pop, no request; then a spurious mem_rsp_valid -> err_o 1 until the next start.
REQ-042 SHALL cover: reset_n low mid-job with 2 outstanding -> all outputs 0 immediately, FSM IDLE; a new job after reset completes normally.
